// File: rtl/alu_bist_ctrl.sv
// Built-in self-test initiator for the single-cycle ALU: walks a 10-entry golden
// table through the ALU, compares Result/Zero and reports pass, error count and first failure.
module alu_bist_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter bit          STOP_ON_FAIL  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [3:0]  err_count,
   output logic [3:0]  fail_idx
);

   localparam logic [3:0] LAST_IDX    = 4'd9;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] NO_FAIL     = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      FINISH
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  idx;
   logic [3:0]  settle_cnt;
   logic [3:0]  rom_ctrl;
   logic [31:0] rom_a;
   logic [31:0] rom_b;
   logic [31:0] rom_exp;
   logic        rom_zero;
   logic        launch;
   logic        kill;
   logic        mismatch;
   logic        finish;

   // Golden vector table: operands, opcode and the expected ALU response.
   always_comb begin
      rom_ctrl = 4'h0;
      rom_a    = '0;
      rom_b    = '0;
      rom_exp  = '0;
      rom_zero = 1'b0;
      case (idx)
         4'd0: begin rom_ctrl = 4'h0; rom_a = 32'h0000000A; rom_b = 32'h00000014; rom_exp = 32'h0000001E; rom_zero = 1'b0; end
         4'd1: begin rom_ctrl = 4'h1; rom_a = 32'h00000019; rom_b = 32'h00000019; rom_exp = 32'h00000000; rom_zero = 1'b1; end
         4'd2: begin rom_ctrl = 4'h2; rom_a = 32'hF0F0F0F0; rom_b = 32'h0F0F0F0F; rom_exp = 32'h00000000; rom_zero = 1'b1; end
         4'd3: begin rom_ctrl = 4'h3; rom_a = 32'hAAAA5555; rom_b = 32'h5555AAAA; rom_exp = 32'hFFFFFFFF; rom_zero = 1'b0; end
         4'd4: begin rom_ctrl = 4'h4; rom_a = 32'hFFFFFFFF; rom_b = 32'h0000FFFF; rom_exp = 32'hFFFF0000; rom_zero = 1'b0; end
         4'd5: begin rom_ctrl = 4'h5; rom_a = 32'h00000001; rom_b = 32'h00000005; rom_exp = 32'h00000020; rom_zero = 1'b0; end
         4'd6: begin rom_ctrl = 4'h6; rom_a = 32'h80000000; rom_b = 32'h00000004; rom_exp = 32'h08000000; rom_zero = 1'b0; end
         4'd7: begin rom_ctrl = 4'h7; rom_a = 32'hFFFFFFF8; rom_b = 32'h00000002; rom_exp = 32'hFFFFFFFE; rom_zero = 1'b0; end
         4'd8: begin rom_ctrl = 4'h8; rom_a = 32'hFFFFFFF6; rom_b = 32'h00000005; rom_exp = 32'h00000001; rom_zero = 1'b0; end
         4'd9: begin rom_ctrl = 4'h8; rom_a = 32'h00000014; rom_b = 32'h0000000A; rom_exp = 32'h00000000; rom_zero = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      launch   = (state == IDLE) && start && !abort;
      kill     = (state != IDLE) && abort;
      mismatch = (alu_result != rom_exp) || (alu_zero != rom_zero);
      finish   = (idx == LAST_IDX) || (mismatch && STOP_ON_FAIL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = DRIVE;
         DRIVE:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
         CHECK:   state_nxt = finish ? FINISH : DRIVE;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill) begin
         state_nxt = IDLE;
      end
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == FINISH);
   end

   // Abort takes priority over every in-flight update so partial results stay frozen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx        <= '0;
         settle_cnt <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_idx   <= NO_FAIL;
      end else if (kill) begin
         pass <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  idx       <= '0;
                  err_count <= '0;
                  fail_idx  <= NO_FAIL;
                  pass      <= 1'b0;
               end
            end
            DRIVE: begin
               alu_a      <= rom_a;
               alu_b      <= rom_b;
               alu_ctrl   <= rom_ctrl;
               settle_cnt <= '0;
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
            end
            CHECK: begin
               if (mismatch) begin
                  if (err_count != 4'hF) begin
                     err_count <= err_count + 4'd1;
                  end
                  if (fail_idx == NO_FAIL) begin
                     fail_idx <= idx;
                  end
               end
               if (!finish) begin
                  idx <= idx + 4'd1;
               end
            end
            FINISH: begin
               pass <= (err_count == '0);
            end
            default: ;
         endcase
      end
   end

endmodule
